// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the 4-bit ALU: operand fetch,
// one-cycle execute, register write-back and result reporting.
module alu_cmd_sequencer #(
    parameter int W = 4,
    parameter int NREG = 4,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic          cmd_use_imm,
    input  logic [W-1:0]  cmd_imm,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_op,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_overflow,
    output logic          res_valid,
    output logic [W-1:0]  res_data,
    output logic          res_ovf,
    output logic          res_err,
    output logic          sticky_ovf,
    input  logic          clr_sticky,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t        state;
    logic [W-1:0]  rf [NREG];
    logic [AW-1:0] rd_q;
    logic          err_q;
    logic          arith;

    assign cmd_ready = (state == IDLE);
    assign dbg_data  = rf[dbg_addr];
    assign arith     = (alu_op[2:1] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 3'b000;
            rd_q       <= '0;
            err_q      <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            sticky_ovf <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            // a set in the same cycle as a clear takes priority
            sticky_ovf <= res_ovf | (sticky_ovf & ~clr_sticky);
            res_valid  <= 1'b0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_q   <= cmd_rd;
                        err_q  <= (cmd_op[2:1] == 2'b01);
                        alu_a  <= rf[cmd_rs1];
                        alu_b  <= cmd_use_imm ? cmd_imm
                                              : rf[cmd_rs2];
                        alu_op <= cmd_op;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_valid <= 1'b1;
                    res_data  <= err_q ? '0 : alu_result;
                    res_ovf   <= alu_overflow & arith & ~err_q;
                    res_err   <= err_q;
                    state     <= WB;
                end
                WB: begin
                    if (!err_q) begin
                        rf[rd_q] <= res_data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
